// File: rtl/dualport_ram_tdp.sv
// True dual-port synchronous RAM with post-reset clear sweep, write-write collision
// arbitration, selectable read-during-write behaviour and optional output register.
//
// Handshake: a port request is taken on a rising edge only when en_x && rdy_x;
// there is no back-pressure beyond rdy_x, and requests seen while rdy_x is low are dropped.
// A read produces exactly one vld_x pulse, 1 (OUT_REG=0) or 2 (OUT_REG=1) edges later.
module dualport_ram_tdp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0,
    parameter int COL_PRI  = 0,
    parameter int OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic              w_a,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [DATA_W-1:0] d_in_a,
    output logic              rdy_a,
    output logic [DATA_W-1:0] d_out_a,
    output logic              vld_a,
    input  logic              en_b,
    input  logic              w_b,
    input  logic [ADDR_W-1:0] add_b,
    input  logic [DATA_W-1:0] d_in_b,
    output logic              rdy_b,
    output logic [DATA_W-1:0] d_out_b,
    output logic              vld_b,
    output logic              busy,
    output logic              col
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit B_WINS = (COL_PRI != 0);
    localparam bit RDW_NEW = (RDW_MODE != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_a, acc_b;
    logic              wr_a, wr_b;
    logic              rd_a, rd_b;
    logic              col_now;
    logic              keep_a, keep_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;

    logic              s1_vld_a, s1_vld_b;
    logic [DATA_W-1:0] s1_data_a, s1_data_b;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // busy is the externally visible copy of the sequencer state
    assign busy  = (state == ST_CLEAR);
    assign rdy_a = (state == ST_RUN);
    assign rdy_b = (state == ST_RUN);

    // ---------------- request decode ----------------
    assign acc_a   = en_a && rdy_a;
    assign acc_b   = en_b && rdy_b;
    assign wr_a    = acc_a && w_a;
    assign wr_b    = acc_b && w_b;
    assign rd_a    = acc_a && !w_a;
    assign rd_b    = acc_b && !w_b;
    assign col_now = wr_a && wr_b && (add_a == add_b);

    // The losing write of a collision is simply not performed.
    assign keep_a = wr_a && !(col_now && B_WINS);
    assign keep_b = wr_b && !(col_now && !B_WINS);

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else begin
            if (keep_a) begin
                mem[add_a] <= d_in_a;
            end
            if (keep_b) begin
                mem[add_b] <= d_in_b;
            end
        end
    end

    // Cross-port bypass gives new-data semantics; the plain array read gives old data.
    always_comb begin
        rd_data_a = mem[add_a];
        if (RDW_NEW && wr_b && (add_b == add_a)) begin
            rd_data_a = d_in_b;
        end
    end

    always_comb begin
        rd_data_b = mem[add_b];
        if (RDW_NEW && wr_a && (add_a == add_b)) begin
            rd_data_b = d_in_a;
        end
    end

    // ---------------- first read stage and collision flag ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_a  <= 1'b0;
            s1_vld_b  <= 1'b0;
            s1_data_a <= '0;
            s1_data_b <= '0;
            col       <= 1'b0;
        end else begin
            s1_vld_a <= rd_a;
            s1_vld_b <= rd_b;
            if (rd_a) begin
                s1_data_a <= rd_data_a;
            end
            if (rd_b) begin
                s1_data_b <= rd_data_b;
            end
            col <= col_now;
        end
    end

    // ---------------- optional output register ----------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              p_vld_a, p_vld_b;
            logic [DATA_W-1:0] p_data_a, p_data_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_vld_a  <= 1'b0;
                    p_vld_b  <= 1'b0;
                    p_data_a <= '0;
                    p_data_b <= '0;
                end else begin
                    p_vld_a <= s1_vld_a;
                    p_vld_b <= s1_vld_b;
                    if (s1_vld_a) begin
                        p_data_a <= s1_data_a;
                    end
                    if (s1_vld_b) begin
                        p_data_b <= s1_data_b;
                    end
                end
            end

            assign d_out_a = p_data_a;
            assign vld_a   = p_vld_a;
            assign d_out_b = p_data_b;
            assign vld_b   = p_vld_b;
        end else begin : g_no_out_reg
            assign d_out_a = s1_data_a;
            assign vld_a   = s1_vld_a;
            assign d_out_b = s1_data_b;
            assign vld_b   = s1_vld_b;
        end
    endgenerate

endmodule

// File: tb/tb_dualport_ram_tdp.sv
// Directed bench for dualport_ram_tdp: two instances share stimulus, one with
// old-data / A-wins / latency 1, the other with new-data / B-wins / latency 2.
module tb_dualport_ram_tdp;

    logic       clk;
    logic       rst;
    logic       en_a, w_a, en_b, w_b;
    logic [3:0] add_a, add_b;
    logic [7:0] d_in_a, d_in_b;

    logic       rdy_a0, vld_a0, rdy_b0, vld_b0, busy0, col0;
    logic [7:0] d_out_a0, d_out_b0;
    logic       rdy_a1, vld_a1, rdy_b1, vld_b1, busy1, col1;
    logic [7:0] d_out_a1, d_out_b1;

    int total = 0;
    int bad   = 0;

    dualport_ram_tdp #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0), .COL_PRI(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .w_a(w_a), .add_a(add_a), .d_in_a(d_in_a),
        .rdy_a(rdy_a0), .d_out_a(d_out_a0), .vld_a(vld_a0),
        .en_b(en_b), .w_b(w_b), .add_b(add_b), .d_in_b(d_in_b),
        .rdy_b(rdy_b0), .d_out_b(d_out_b0), .vld_b(vld_b0),
        .busy(busy0), .col(col0)
    );

    dualport_ram_tdp #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1), .COL_PRI(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .w_a(w_a), .add_a(add_a), .d_in_a(d_in_a),
        .rdy_a(rdy_a1), .d_out_a(d_out_a1), .vld_a(vld_a1),
        .en_b(en_b), .w_b(w_b), .add_b(add_b), .d_in_b(d_in_b),
        .rdy_b(rdy_b1), .d_out_b(d_out_b1), .vld_b(vld_b1),
        .busy(busy1), .col(col1)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        en_a = 1'b0;
        w_a  = 1'b0;
        en_b = 1'b0;
        w_b  = 1'b0;
    endtask

    task automatic drv_a(input logic w, input logic [3:0] a, input logic [7:0] d);
        en_a = 1'b1; w_a = w; add_a = a; d_in_a = d;
    endtask

    task automatic drv_b(input logic w, input logic [3:0] a, input logic [7:0] d);
        en_b = 1'b1; w_b = w; add_b = a; d_in_b = d;
    endtask

    task automatic chk_rst(input string tag);
        check({tag, "_busy0"}, 8'(busy0), 8'd1);
        check({tag, "_busy1"}, 8'(busy1), 8'd1);
        check({tag, "_rdy0"}, 8'({rdy_a0, rdy_b0}), 8'd0);
        check({tag, "_rdy1"}, 8'({rdy_a1, rdy_b1}), 8'd0);
        check({tag, "_dout_a0"}, d_out_a0, 8'h00);
        check({tag, "_dout_b0"}, d_out_b0, 8'h00);
        check({tag, "_dout_a1"}, d_out_a1, 8'h00);
        check({tag, "_dout_b1"}, d_out_b1, 8'h00);
        check({tag, "_vld"}, 8'({vld_a0, vld_b0, vld_a1, vld_b1}), 8'd0);
        check({tag, "_col"}, 8'({col0, col1}), 8'd0);
    endtask

    // Counts edges until busy drops, bounded so a stuck sequencer still reaches the report.
    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy0 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_cycles"}, 8'(n), 8'd16);
        check({tag, "_busy1"}, 8'(busy1), 8'd0);
        check({tag, "_rdy0"}, 8'({rdy_a0, rdy_b0}), 8'b11);
        check({tag, "_rdy1"}, 8'({rdy_a1, rdy_b1}), 8'b11);
    endtask

    // Single read on one port; checks both latencies and the single-cycle vld pulse.
    task automatic rd(input logic pb, input logic [3:0] a, input logic [7:0] e0, input logic [7:0] e1);
        if (pb) drv_b(1'b0, a, 8'h00);
        else drv_a(1'b0, a, 8'h00);
        step();
        idle();
        check("rd_vld0", 8'(pb ? vld_b0 : vld_a0), 8'd1);
        check("rd_dat0", pb ? d_out_b0 : d_out_a0, e0);
        check("rd_early1", 8'(pb ? vld_b1 : vld_a1), 8'd0);
        step();
        check("rd_pulse0", 8'(pb ? vld_b0 : vld_a0), 8'd0);
        check("rd_vld1", 8'(pb ? vld_b1 : vld_a1), 8'd1);
        check("rd_dat1", pb ? d_out_b1 : d_out_a1, e1);
    endtask

    function automatic logic [7:0] stream_exp(input int i);
        if (i >= 8) return 8'(8'h80 | (i - 8));
        return 8'(i * 3 + 1);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int pulses0;
        int pulses1;
        rst = 1'b1;
        idle();
        add_a = '0; add_b = '0; d_in_a = '0; d_in_b = '0;
        repeat (2) @(negedge clk);
        chk_rst("reset");

        // T1: clear sweep length and all-zero contents
        rst = 1'b0;
        wait_clear("t1_busy");
        for (int i = 0; i < 16; i++) begin
            rd(1'(i % 2), 4'(i), 8'h00, 8'h00);
        end

        // T2: write then read, both latencies; dual-port read of one word
        drv_a(1'b1, 4'd3, 8'hA5);
        step();
        idle();
        check("t2_wr_no_vld", 8'({vld_a0, vld_a1}), 8'd0);
        rd(1'b0, 4'd3, 8'hA5, 8'hA5);
        drv_a(1'b0, 4'd3, 8'h00);
        drv_b(1'b0, 4'd3, 8'h00);
        step();
        idle();
        check("t2_both_a0", d_out_a0, 8'hA5);
        check("t2_both_b0", d_out_b0, 8'hA5);
        check("t2_both_col0", 8'(col0), 8'd0);
        step();
        check("t2_both_a1", d_out_a1, 8'hA5);
        check("t2_both_b1", d_out_b1, 8'hA5);

        // T3: write-write collision
        drv_a(1'b1, 4'd7, 8'h11);
        drv_b(1'b1, 4'd7, 8'h22);
        step();
        idle();
        check("t3_col0", 8'(col0), 8'd1);
        check("t3_col1", 8'(col1), 8'd1);
        step();
        check("t3_col_pulse", 8'({col0, col1}), 8'd0);
        rd(1'b0, 4'd7, 8'h11, 8'h22);
        rd(1'b1, 4'd7, 8'h11, 8'h22);

        // T4: read-during-write across ports
        drv_a(1'b1, 4'd5, 8'h33);
        step();
        idle();
        drv_a(1'b1, 4'd5, 8'h44);
        drv_b(1'b0, 4'd5, 8'h00);
        step();
        idle();
        check("t4_vld_b0", 8'(vld_b0), 8'd1);
        check("t4_old_b0", d_out_b0, 8'h33);
        check("t4_col0", 8'(col0), 8'd0);
        step();
        check("t4_vld_b1", 8'(vld_b1), 8'd1);
        check("t4_new_b1", d_out_b1, 8'h44);
        check("t4_col1", 8'(col1), 8'd0);
        rd(1'b0, 4'd5, 8'h44, 8'h44);

        // T6: streaming reads on A alongside writes on B
        for (int i = 0; i < 16; i++) begin
            drv_a(1'b1, 4'(i), 8'(i * 3 + 1));
            step();
        end
        idle();
        pulses0 = 0;
        pulses1 = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                drv_a(1'b0, 4'(i), 8'h00);
                drv_b(1'b1, 4'((i + 8) % 16), 8'(8'h80 | i));
            end else begin
                idle();
            end
            step();
            if (vld_a0) pulses0++;
            if (vld_a1) pulses1++;
            if (i < 16) begin
                check("t6_vld0", 8'(vld_a0), 8'd1);
                check("t6_dat0", d_out_a0, stream_exp(i));
            end else begin
                check("t6_tail0", 8'(vld_a0), 8'd0);
            end
            if (i >= 1 && i <= 16) begin
                check("t6_vld1", 8'(vld_a1), 8'd1);
                check("t6_dat1", d_out_a1, stream_exp(i - 1));
            end else begin
                check("t6_edge1", 8'(vld_a1), 8'd0);
            end
        end
        idle();
        check("t6_pulses0", 8'(pulses0), 8'd16);
        check("t6_pulses1", 8'(pulses1), 8'd16);

        // T5: reset mid-operation and mid-sweep
        rst = 1'b1;
        #1;
        chk_rst("t5_rst_run");
        @(negedge clk);
        rst = 1'b0;
        repeat (9) step();
        check("t5_busy_mid", 8'(busy0), 8'd1);
        rst = 1'b1;
        #1;
        chk_rst("t5_rst_mid");
        @(negedge clk);
        rst = 1'b0;
        drv_a(1'b1, 4'd2, 8'hFF);
        drv_b(1'b1, 4'd12, 8'hFF);
        wait_clear("t5_busy");
        idle();
        rd(1'b0, 4'd2, 8'h00, 8'h00);
        rd(1'b1, 4'd12, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
